// File: rtl/loa_corruption_monitor.sv
// Measures output corruption of a key-locked lower-part-OR adder over a window of vectors.
// Recomputes the golden result, then pipelines XOR -> popcount -> statistics accumulation.
module loa_corruption_monitor #(
    parameter int WIDTH  = 16,
    parameter int LOWER  = 8,
    parameter int WINDOW = 5001,
    parameter int CNT_W  = 16,
    parameter int HD_W   = 24
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [WIDTH-1:0]              add1_i,
    input  logic [WIDTH-1:0]              add2_i,
    input  logic [WIDTH:0]                locked_result_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [CNT_W-1:0]              err_vec_cnt_o,
    output logic [HD_W-1:0]               hd_sum_o,
    output logic [$clog2(WIDTH+2)-1:0]    max_hd_o
);

    localparam int PC_W  = $clog2(WIDTH + 2);
    localparam int ACC_W = $clog2(WINDOW + 1);
    localparam int UP_W  = WIDTH - LOWER;
    localparam int HDX_W = HD_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [ACC_W-1:0]   r_acc_cnt;

    logic [WIDTH:0]     r_x;
    logic               r_v1;
    logic [PC_W-1:0]    r_pc;
    logic               r_v2;

    logic [CNT_W-1:0]   r_err;
    logic [HD_W-1:0]    r_hd;
    logic [PC_W-1:0]    r_max;

    logic               w_accept;
    logic               w_start;
    logic               w_last;
    logic [LOWER-1:0]   w_g_lo;
    logic               w_c;
    logic [UP_W:0]      w_g_hi;
    logic [WIDTH:0]     w_golden;
    logic [PC_W-1:0]    w_pc;
    logic [HDX_W-1:0]   w_hd_sum;
    logic [HD_W-1:0]    w_hd_next;
    logic [CNT_W-1:0]   w_err_next;

    assign w_accept = valid_i && r_ready;
    assign w_start  = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_acc_cnt == ACC_W'(WINDOW - 1));

    // Golden LOA: OR in the low part, carry-in to the upper adder from the top low bits' AND
    assign w_g_lo   = add1_i[LOWER-1:0] | add2_i[LOWER-1:0];
    assign w_c      = add1_i[LOWER-1] & add2_i[LOWER-1];
    assign w_g_hi   = {1'b0, add1_i[WIDTH-1:LOWER]} + {1'b0, add2_i[WIDTH-1:LOWER]}
                    + (UP_W+1)'(w_c);
    assign w_golden = {w_g_hi, w_g_lo};

    always_comb begin
        w_pc = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            w_pc = w_pc + PC_W'(r_x[i]);
        end
    end

    assign w_hd_sum   = {1'b0, r_hd} + HDX_W'(r_pc);
    assign w_hd_next  = w_hd_sum[HD_W] ? '1 : w_hd_sum[HD_W-1:0];
    assign w_err_next = ((r_pc != '0) && (r_err != '1)) ? r_err + CNT_W'(1) : r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_acc_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_state   <= S_RUN;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_acc_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_acc_cnt <= r_acc_cnt + ACC_W'(1);
                        if (w_last) begin
                            r_state <= S_DRAIN;
                            r_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // Both stage valids low means the final accumulate landed on the previous edge
                    if (!r_v1 && !r_v2) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_x  <= '0;
            r_v1 <= 1'b0;
            r_pc <= '0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_accept;
            r_x  <= w_golden ^ locked_result_i;
            r_v2 <= r_v1;
            r_pc <= w_pc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= '0;
            r_hd  <= '0;
            r_max <= '0;
        end else if (w_start) begin
            r_err <= '0;
            r_hd  <= '0;
            r_max <= '0;
        end else if (r_v2) begin
            r_err <= w_err_next;
            r_hd  <= w_hd_next;
            if (r_pc > r_max) begin
                r_max <= r_pc;
            end
        end
    end

    assign ready_o       = r_ready;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_vec_cnt_o = r_err;
    assign hd_sum_o      = r_hd;
    assign max_hd_o      = r_max;

endmodule

// File: tb/tb_loa_corruption_monitor.sv
// Drives three monitor instances (WINDOW 1, 3, 5 with narrow saturating counters) and
// compares every cycle against a transaction-level model of the expected statistics.
module tb_loa_corruption_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [16:0] locked = '0;
    logic [2:0]  start = '0;
    logic [2:0]  ready, busy, done;
    logic [15:0] err0, err1;
    logic [1:0]  err2;
    logic [23:0] hd0, hd1;
    logic [5:0]  hd2;
    logic [4:0]  mx0, mx1, mx2;

    always #5 clk = ~clk;

    loa_corruption_monitor #(.WIDTH(16), .LOWER(8), .WINDOW(1), .CNT_W(16), .HD_W(24)) dutW1 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .valid_i(valid), .ready_o(ready[0]),
        .add1_i(a), .add2_i(b), .locked_result_i(locked), .busy_o(busy[0]), .done_o(done[0]),
        .err_vec_cnt_o(err0), .hd_sum_o(hd0), .max_hd_o(mx0));

    loa_corruption_monitor #(.WIDTH(16), .LOWER(8), .WINDOW(3), .CNT_W(16), .HD_W(24)) dutW3 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .valid_i(valid), .ready_o(ready[1]),
        .add1_i(a), .add2_i(b), .locked_result_i(locked), .busy_o(busy[1]), .done_o(done[1]),
        .err_vec_cnt_o(err1), .hd_sum_o(hd1), .max_hd_o(mx1));

    loa_corruption_monitor #(.WIDTH(16), .LOWER(8), .WINDOW(5), .CNT_W(2), .HD_W(6)) dutSat (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .valid_i(valid), .ready_o(ready[2]),
        .add1_i(a), .add2_i(b), .locked_result_i(locked), .busy_o(busy[2]), .done_o(done[2]),
        .err_vec_cnt_o(err2), .hd_sum_o(hd2), .max_hd_o(mx2));

    int          sel = 1;
    logic        curReady, curBusy, curDone;
    logic [31:0] curErr, curHd, curMax;

    always_comb begin
        curReady = ready[1];
        curBusy  = busy[1];
        curDone  = done[1];
        curErr   = 32'(err1);
        curHd    = 32'(hd1);
        curMax   = 32'(mx1);
        case (sel)
            0: begin
                curReady = ready[0]; curBusy = busy[0]; curDone = done[0];
                curErr = 32'(err0); curHd = 32'(hd0); curMax = 32'(mx0);
            end
            2: begin
                curReady = ready[2]; curBusy = busy[2]; curDone = done[2];
                curErr = 32'(err2); curHd = 32'(hd2); curMax = 32'(mx2);
            end
            default: ;
        endcase
    end

    // Reference model: per-instance run bookkeeping plus a 3-cycle delay queue of popcounts
    int window[3] = '{1, 3, 5};
    int errMax[3] = '{65535, 65535, 3};
    int hdMax[3]  = '{16777215, 16777215, 63};
    bit runActive[3];
    int accCnt[3];
    int finishCyc[3];
    int expErr[3];
    int expHd[3];
    int expMax[3];
    int dq[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s (dut %0d, cycle %0d): got %0d expected %0d", tag, sel, cyc, obs, exp);
        end
    endtask

    function automatic logic [16:0] goldenOf(input logic [15:0] av, input logic [15:0] bv);
        int lo, c, hi;
        lo = (int'(av) | int'(bv)) & 8'hFF;
        c  = (int'(av) >> 7) & (int'(bv) >> 7) & 1;
        hi = (int'(av) >> 8) + (int'(bv) >> 8) + c;
        return 17'((hi << 8) | lo);
    endfunction

    function automatic logic [16:0] randLocked(input logic [15:0] av, input logic [15:0] bv);
        logic [16:0] g;
        logic [16:0] one;
        g   = goldenOf(av, bv);
        one = 17'd1;
        case ($urandom_range(0, 3))
            0:       return g;
            1:       return g ^ (one << $urandom_range(0, 16));
            2:       return ~g;
            default: return 17'($urandom);
        endcase
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 3; i++) begin
            runActive[i] = 1'b0;
            accCnt[i]    = 0;
            finishCyc[i] = -1;
            expErr[i]    = 0;
            expHd[i]     = 0;
            expMax[i]    = 0;
        end
        dq.delete();
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] av, input logic [15:0] bv,
                                 input logic [16:0] lv, input logic st);
        int p;
        bit busyExp;
        @(negedge clk);
        while (dq.size() > 2) begin
            p = dq.pop_front();
            if (p >= 0) begin
                if (p != 0 && expErr[sel] < errMax[sel]) expErr[sel]++;
                expHd[sel] = (expHd[sel] + p > hdMax[sel]) ? hdMax[sel] : expHd[sel] + p;
                if (p > expMax[sel]) expMax[sel] = p;
            end
        end
        busyExp = runActive[sel] || (cyc < finishCyc[sel]);
        checkOutput("ready", 32'(curReady), 32'(runActive[sel]));
        checkOutput("busy", 32'(curBusy), 32'(busyExp));
        checkOutput("done", 32'(curDone), 32'(cyc == finishCyc[sel]));
        checkOutput("errVecCnt", curErr, 32'(expErr[sel]));
        checkOutput("hdSum", curHd, 32'(expHd[sel]));
        checkOutput("maxHd", curMax, 32'(expMax[sel]));
        valid  = v;
        a      = av;
        b      = bv;
        locked = lv;
        start  = st ? (3'b001 << sel) : 3'b000;
        if (v && runActive[sel]) begin
            dq.push_back($countones(goldenOf(av, bv) ^ lv));
            accCnt[sel]++;
            if (accCnt[sel] == window[sel]) begin
                runActive[sel] = 1'b0;
                finishCyc[sel] = cyc + 4;
            end
        end else begin
            dq.push_back(-1);
        end
        if (st && !busyExp) begin
            runActive[sel] = 1'b1;
            accCnt[sel]    = 0;
            finishCyc[sel] = -1;
            expErr[sel]    = 0;
            expHd[sel]     = 0;
            expMax[sel]    = 0;
            dq.delete();
        end
        cyc++;
    endtask

    task automatic doReset();
        @(negedge clk);
        valid = 1'b0;
        start = '0;
        rst   = 1'b1;
        #1;
        checkOutput("rstReady", 32'(curReady), 32'd0);
        checkOutput("rstBusy", 32'(curBusy), 32'd0);
        checkOutput("rstDone", 32'(curDone), 32'd0);
        checkOutput("rstErr", curErr, 32'd0);
        checkOutput("rstHd", curHd, 32'd0);
        checkOutput("rstMax", curMax, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clearModel();
    endtask

    task automatic idleCycles(input int n, input logic v);
        for (int i = 0; i < n; i++) applyStimulus(v, 16'h00FF, 16'h0001, 17'h1FF00, 1'b0);
    endtask

    task automatic randomRun(input int s);
        logic [15:0] ra, rb;
        sel = s;
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            applyStimulus((i >= 20) || ($urandom_range(0, 9) < 7), ra, rb, randLocked(ra, rb),
                          1'b0);
        end
    endtask

    initial begin
        clearModel();
        doReset();

        // WINDOW=3: valid in IDLE ignored, then all-golden run
        sel = 1;
        idleCycles(2, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 17'h000FF, 1'b0);
        applyStimulus(1'b1, 16'h1280, 16'h0380, 17'h01680, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 17'h000FF, 1'b0);
        idleCycles(6, 1'b0);

        // Full inversion plus matching vectors, restarted from DONE
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 17'h1FF00, 1'b0);
        applyStimulus(1'b1, 16'h1280, 16'h0380, 17'h01680, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 17'h000FF, 1'b0);
        idleCycles(6, 1'b0);

        // Handshake gaps 1,0,1,0,1,1 then valid held high through DONE
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b1, 16'h1280, 16'h0380, 17'h01681, 1'b0);
        applyStimulus(1'b0, 16'h1280, 16'h0380, 17'h00000, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 17'h000FC, 1'b0);
        applyStimulus(1'b0, 16'h1280, 16'h0380, 17'h00000, 1'b0);
        applyStimulus(1'b1, 16'h1280, 16'h0380, 17'h01680, 1'b1);
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 17'h1FF00, 1'b1);
        idleCycles(8, 1'b1);

        // WINDOW=1 single-bit error
        sel = 0;
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b1, 16'h1280, 16'h0380, 17'h01681, 1'b0);
        idleCycles(6, 1'b0);

        // Reset mid-run, then a fresh run on the saturating instance
        sel = 2;
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 17'h1FF00, 1'b0);
        applyStimulus(1'b1, 16'h1280, 16'h0380, 17'h01681, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        doReset();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h1280, 16'h0380, 17'h01688, 1'b0);
        idleCycles(6, 1'b0);

        // Saturation: five fully inverted vectors
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'h00FF, 16'h0001, 17'h1FF00, 1'b0);
        idleCycles(6, 1'b0);

        for (int r = 0; r < 15; r++) randomRun(r % 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loa_corruption_monitor.md
Name: loa_corruption_monitor

Overview:
- Downstream consumer of the key-locked lower-part-OR ripple-carry adder.
- Each cycle it takes one operand pair plus the locked adder's result and recomputes the golden lower-part-OR result internally.
- Over a window of WINDOW vectors it counts mismatching vectors, accumulates output Hamming distance and tracks the worst-case per-vector distance.
- Used per key-trial run to quantify output corruption for wrong keys.

Parameters:
- WIDTH, 16, operand width; result width is WIDTH+1.
- LOWER, 8, number of low bits computed by OR (1 <= LOWER < WIDTH).
- WINDOW, 5001, vectors per measurement run (>= 1).
- CNT_W, 16, width of vector counters.
- HD_W, 24, width of the Hamming-distance accumulator.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  begin a run; sampled only in IDLE or DONE.
- valid_i  in  1  operand/result triple valid this cycle.
- ready_o  out  1  high only in RUN; a vector is accepted when valid_i && ready_o.
- add1_i  in  WIDTH  operand A as applied to the locked adder.
- add2_i  in  WIDTH  operand B.
- locked_result_i  in  WIDTH+1  result_o of the locked adder for this pair.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse when the run's statistics are final.
- err_vec_cnt_o  out  CNT_W  number of accepted vectors with any bit mismatch.
- hd_sum_o  out  HD_W  sum of per-vector Hamming distances.
- max_hd_o  out  clog2(WIDTH+2)  largest single-vector Hamming distance.

Behaviour:
- Reset (async, rst_i=1): state=IDLE; ready_o=0, busy_o=0, done_o=0; all counters, statistics and pipeline valid bits = 0. Reset mid-run abandons the run.
- Golden model:
  - g[LOWER-1:0] = A|B.
  - c = A[LOWER-1] & B[LOWER-1].
  - g[WIDTH:LOWER] = A[WIDTH-1:LOWER] + B[WIDTH-1:LOWER] + c, zero-extended, carry-out in g[WIDTH].
- Pipeline:
  - S1 registers x = g ^ locked_result_i and v1 = accept.
  - S2 registers popcount(x) and v2 = v1.
  - The accumulate stage updates statistics from S2.
  - Latency: an accepted vector is reflected in the outputs 3 cycles after acceptance.
- States:
  - IDLE: ready_o=0. start_i -> RUN; on that edge clear statistics and accept counter.
  - RUN: ready_o=1. Each accept increments the accept counter. The accept that makes the count = WINDOW moves to DRAIN on the same edge; ready_o drops the next cycle.
  - DRAIN: ready_o=0, busy_o=1. Wait until v1 and v2 are both 0 and the last accumulate has completed, then go to DONE and pulse done_o for one cycle.
  - DONE: statistics held stable. start_i -> RUN with statistics cleared.
  - valid_i while not in RUN is ignored: no count, no pipeline entry.
  - start_i in RUN or DRAIN is ignored.
- Accumulation per valid S2 entry (popcount p):
  - err_vec_cnt_o += (p != 0).
  - hd_sum_o += p.
  - max_hd_o = max(max_hd_o, p).
- Saturation: err_vec_cnt_o and hd_sum_o saturate at all-ones and never wrap.
- Outputs update live during RUN/DRAIN. They are final only when done_o pulses.
- Gaps in valid_i during RUN are allowed. Back-to-back accepts sustain 1 vector/cycle.
- WINDOW=1: one accept goes RUN->DRAIN; done_o fires 4 cycles after the accept.

Test Plan:
- Golden match: WIDTH=16, LOWER=8, WINDOW=2. Vectors A=0x00FF,B=0x0001,locked=0x000FF and A=0x1280,B=0x0380,locked=0x01680 -> done_o pulses once; err_vec_cnt_o=0, hd_sum_o=0, max_hd_o=0.
- Single-bit error: A=0x1280,B=0x0380,locked=0x01681, WINDOW=1 -> err_vec_cnt_o=1, hd_sum_o=1, max_hd_o=1; done_o 4 cycles after the accept.
- Full inversion: A=0x00FF,B=0x0001,locked=0x1FF00 (= ~0x000FF over 17 bits), plus one matching vector, WINDOW=2 -> err_vec_cnt_o=1, hd_sum_o=17, max_hd_o=17.
- Handshake: WINDOW=3 with valid_i toggling 1,0,1,0,1,1 -> exactly 3 accepts; ready_o low after the 3rd; the 6th valid is ignored; valid_i in IDLE/DONE has no effect.
- Reset mid-run: assert rst_i after 2 of 5 accepts -> all outputs 0 immediately, state IDLE. A new start_i then yields stats for the new run only.
- Saturation: CNT_W=2, WINDOW=5, all vectors mismatched -> err_vec_cnt_o holds 3; no wrap to 0.
